// File: rtl/word_field_reader_pkg.sv
// Shared types for the packed-word field reader: word layout, FSM states, default sizes.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package word_field_reader_pkg;

   localparam int DEF_FIELD_W = 8;
   localparam int DEF_NFIELDS = 2;

   // Register-file word as seen by the writer: high field in the upper bits.
   typedef struct packed {
      logic [DEF_FIELD_W-1:0] high;
      logic [DEF_FIELD_W-1:0] low;
   } word_t;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      EMIT
   } rd_state_t;

endpackage

// File: rtl/word_field_reader_fifo.sv
// Generic DEPTH-entry FIFO with registered empty flag and registered push-ready.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: push_rdy is registered (low while full), so there is no comb path from pop to push_rdy.
module word_field_reader_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_dat,
   output logic             empty,
   output logic             push_rdy
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic [AW:0]      cnt_next;

   // occupancy after this cycle's push/pop, used to register the flags
   always_comb begin
      cnt_next = cnt;
      if (push && !pop) begin
         cnt_next = cnt + 1'b1;
      end else if (!push && pop) begin
         cnt_next = cnt - 1'b1;
      end
   end

   // pointers, occupancy and registered flags; push_rdy stays low through reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
         empty    <= 1'b1;
         push_rdy <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         cnt      <= cnt_next;
         empty    <= (cnt_next == '0);
         push_rdy <= (cnt_next != (AW+1)'(DEPTH));
      end
   end

   // storage; data needs no reset because the flags gate every read
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_dat;
   end

   assign pop_dat = mem[rd_ptr];

endmodule

// File: rtl/word_field_reader.sv
// Streams the written fields of buffered packed words, one field per beat, skipping unwritten ones.
// Latency: first beat valid 2 cycles after a word is accepted while idle; one LOAD bubble between words.
// Backpressure: out_ready low holds the current beat stable; in_ready (registered) drops when the buffer is full.
module word_field_reader
   import word_field_reader_pkg::*;
#(
   parameter int FIELD_W    = DEF_FIELD_W,
   parameter int NFIELDS    = DEF_NFIELDS,
   parameter bit HIGH_FIRST = 1'b1,
   parameter int DEPTH      = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [NFIELDS*FIELD_W-1:0] in_word,
   input  logic [NFIELDS-1:0]         in_fmask,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [FIELD_W-1:0]         out_field,
   output logic [$clog2(NFIELDS)-1:0] out_idx,
   output logic                       out_last,
   output logic [7:0]                 drop_cnt
);
   localparam int WORD_W = NFIELDS * FIELD_W;
   localparam int IDX_W  = $clog2(NFIELDS);
   localparam int ENT_W  = WORD_W + NFIELDS;

   rd_state_t          state;
   logic [WORD_W-1:0]  word_q;
   logic [NFIELDS-1:0] rem_q;
   logic               in_acc;
   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_empty;
   logic [ENT_W-1:0]   head_dat;
   logic [WORD_W-1:0]  src_word;
   logic [NFIELDS-1:0] src_mask;
   logic [NFIELDS-1:0] rem_next;
   logic [IDX_W-1:0]   pick_idx;
   logic [FIELD_W-1:0] pick_field;
   logic               pick_last;

   assign in_acc    = in_valid & in_ready;
   assign fifo_push = in_acc & (|in_fmask);
   assign fifo_pop  = (state == LOAD);

   word_field_reader_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (fifo_push),
      .push_dat ({in_fmask, in_word}),
      .pop      (fifo_pop),
      .pop_dat  (head_dat),
      .empty    (fifo_empty),
      .push_rdy (in_ready)
   );

   // pick the next field: from the buffer head while loading, otherwise from the remaining mask
   always_comb begin
      src_word = (state == LOAD) ? head_dat[WORD_W-1:0] : word_q;
      src_mask = (state == LOAD) ? head_dat[ENT_W-1:WORD_W] : rem_q;
      pick_idx = '0;
      if (HIGH_FIRST) begin
         for (int i = 0; i < NFIELDS; i++) begin
            if (src_mask[i]) pick_idx = IDX_W'(i);
         end
      end else begin
         for (int i = NFIELDS - 1; i >= 0; i--) begin
            if (src_mask[i]) pick_idx = IDX_W'(i);
         end
      end
      pick_field = '0;
      for (int i = 0; i < NFIELDS; i++) begin
         if (IDX_W'(i) == pick_idx) pick_field = src_word[i*FIELD_W +: FIELD_W];
      end
      rem_next           = src_mask;
      rem_next[pick_idx] = 1'b0;
      pick_last          = (rem_next == '0);
   end

   // load/emit sequencer with registered beat outputs held while the consumer stalls
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         word_q    <= '0;
         rem_q     <= '0;
         out_valid <= 1'b0;
         out_field <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!fifo_empty) state <= LOAD;
            end
            LOAD: begin
               word_q    <= src_word;
               rem_q     <= rem_next;
               out_valid <= 1'b1;
               out_field <= pick_field;
               out_idx   <= pick_idx;
               out_last  <= pick_last;
               state     <= EMIT;
            end
            EMIT: begin
               if (out_ready) begin
                  if (out_last) begin
                     out_valid <= 1'b0;
                     state     <= fifo_empty ? IDLE : LOAD;
                  end else begin
                     rem_q     <= rem_next;
                     out_field <= pick_field;
                     out_idx   <= pick_idx;
                     out_last  <= pick_last;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // count words that arrive with nothing written; saturates rather than wrapping
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (in_acc && (in_fmask == '0) && (drop_cnt != 8'hFF)) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_word_field_reader.sv
// Self-checking bench for word_field_reader: vector table plus scoreboard-checked beats.
// Latency: checks the 2-cycle first-beat latency from idle.
// Backpressure: exercises consumer stalls, a full buffer, drops and reset mid-word.
`timescale 1ns/1ps
module tb_word_field_reader;
   import word_field_reader_pkg::*;

   typedef struct {
      logic [7:0] field;
      logic       idx;
      logic       last;
   } beat_t;

   typedef struct {
      word_t      word;
      logic [1:0] mask;
      int         n;
      logic [7:0] f0;
      logic       i0;
      logic [7:0] f1;
      logic       i1;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_word = '0;
   logic [1:0]  in_fmask = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  out_field;
   logic [0:0]  out_idx;
   logic        out_last;
   logic [7:0]  drop_cnt;

   logic        b_in_valid = 1'b0;
   logic        b_in_ready;
   logic [15:0] b_in_word = '0;
   logic [1:0]  b_in_fmask = '0;
   logic        b_out_valid;
   logic        b_out_ready = 1'b1;
   logic [7:0]  b_out_field;
   logic [0:0]  b_out_idx;
   logic        b_out_last;
   logic [7:0]  b_drop_cnt;

   int    total = 0;
   int    bad = 0;
   beat_t exp_q[$];
   beat_t expb_q[$];

   always #5 clk = ~clk;

   word_field_reader #(.FIELD_W(8), .NFIELDS(2), .HIGH_FIRST(1'b1), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_fmask(in_fmask),
      .out_valid(out_valid), .out_ready(out_ready), .out_field(out_field),
      .out_idx(out_idx), .out_last(out_last), .drop_cnt(drop_cnt)
   );

   word_field_reader #(.FIELD_W(8), .NFIELDS(2), .HIGH_FIRST(1'b0), .DEPTH(2)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_word(b_in_word), .in_fmask(b_in_fmask),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_field(b_out_field),
      .out_idx(b_out_idx), .out_last(b_out_last), .drop_cnt(b_drop_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic expect_a(input logic [7:0] f, input logic i, input logic l);
      beat_t b;
      b.field = f; b.idx = i; b.last = l;
      exp_q.push_back(b);
   endtask

   task automatic expect_b(input logic [7:0] f, input logic i, input logic l);
      beat_t b;
      b.field = f; b.idx = i; b.last = l;
      expb_q.push_back(b);
   endtask

   // Scoreboard for the high-first instance: every accepted beat must match the queue head.
   always @(negedge clk) begin
      beat_t e;
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL a_unexpected_beat: got field=%h idx=%0d last=%0d with nothing expected",
                     out_field, out_idx, out_last);
         end else begin
            e = exp_q.pop_front();
            chk("a_beat{field,idx,last}", {22'd0, out_field, out_idx, out_last},
                {22'd0, e.field, e.idx, e.last});
         end
      end
   end

   // Scoreboard for the low-first instance.
   always @(negedge clk) begin
      beat_t e;
      if (rst_n && b_out_valid && b_out_ready) begin
         if (expb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL b_unexpected_beat: got field=%h idx=%0d last=%0d with nothing expected",
                     b_out_field, b_out_idx, b_out_last);
         end else begin
            e = expb_q.pop_front();
            chk("b_beat{field,idx,last}", {22'd0, b_out_field, b_out_idx, b_out_last},
                {22'd0, e.field, e.idx, e.last});
         end
      end
   end

   task automatic send(input logic [15:0] w, input logic [1:0] m);
      int g = 0;
      @(negedge clk);
      in_valid = 1'b1; in_word = w; in_fmask = m;
      while (!in_ready && g < 200) begin
         @(negedge clk);
         g++;
      end
      total++;
      if (g >= 200) begin
         bad++;
         $display("FAIL send_wait: in_ready still 0 after %0d cycles, want 1", g);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int g = 0;
      while ((exp_q.size() != 0 || expb_q.size() != 0) && g < 500) begin
         @(negedge clk);
         g++;
      end
      total++;
      if (g >= 500) begin
         bad++;
         $display("FAIL %s: %0d beats pending after %0d cycles, want 0", name,
                  exp_q.size() + expb_q.size(), g);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      vec_t        tbl[6];
      logic [15:0] xw;
      int          g;

      tbl[0] = '{16'hABCD, 2'b11, 2, 8'hAB, 1'b1, 8'hCD, 1'b0};
      tbl[1] = '{16'h7F00, 2'b10, 1, 8'h7F, 1'b1, 8'h00, 1'b0};
      tbl[2] = '{16'h1234, 2'b01, 1, 8'h34, 1'b0, 8'h00, 1'b0};
      tbl[3] = '{16'h5A00, 2'b00, 0, 8'h00, 1'b0, 8'h00, 1'b0};
      tbl[4] = '{16'h0099, 2'b10, 1, 8'h00, 1'b1, 8'h00, 1'b0};
      tbl[5] = '{16'hC3E1, 2'b01, 1, 8'hE1, 1'b0, 8'h00, 1'b0};

      // reset values
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_field", {24'd0, out_field}, 32'd0);
      chk("rst_out_idx", {31'd0, out_idx}, 32'd0);
      chk("rst_out_last", {31'd0, out_last}, 32'd0);
      chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

      // full word, high first, with first-beat latency
      out_ready = 1'b1;
      expect_a(8'hFF, 1'b1, 1'b0);
      expect_a(8'h00, 1'b0, 1'b1);
      send(16'hFF00, 2'b11);
      @(negedge clk); chk("lat_cycle0_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk); chk("lat_cycle1_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk); chk("lat_cycle2_valid", {31'd0, out_valid}, 32'd1);
      drain("drain_first_word");

      // vector table, words back to back
      for (int i = 0; i < 6; i++) begin
         if (tbl[i].n >= 1) expect_a(tbl[i].f0, tbl[i].i0, tbl[i].n == 1);
         if (tbl[i].n == 2) expect_a(tbl[i].f1, tbl[i].i1, 1'b1);
         send(tbl[i].word, tbl[i].mask);
      end
      drain("drain_table");
      chk("table_drop_cnt", {24'd0, drop_cnt}, 32'd1);

      // unknown nibbles pass through untouched; partial write on the second word
      xw = 16'hxF_x0;
      expect_a(xw[15:8], 1'b1, 1'b0);
      expect_a(xw[7:0], 1'b0, 1'b1);
      expect_a(8'h7F, 1'b1, 1'b1);
      send(xw, 2'b11);
      send(16'h7F00, 2'b10);
      drain("drain_xwords");

      // a long run of empty-mask words: counted, never emitted, counter saturates
      @(negedge clk);
      in_valid = 1'b1; in_word = 16'hDEAD; in_fmask = 2'b00;
      repeat (100) @(posedge clk);
      #1;
      chk("drop_cnt_mid", {24'd0, drop_cnt}, 32'd101);
      chk("drop_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (200) @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("drop_cnt_sat", {24'd0, drop_cnt}, 32'd255);
      chk("drop_no_valid", {31'd0, out_valid}, 32'd0);

      // consumer stall with three words offered
      out_ready = 1'b0;
      expect_a(8'hA1, 1'b1, 1'b0); expect_a(8'hB1, 1'b0, 1'b1);
      expect_a(8'hA2, 1'b1, 1'b0); expect_a(8'hB2, 1'b0, 1'b1);
      expect_a(8'hA3, 1'b1, 1'b0); expect_a(8'hB3, 1'b0, 1'b1);
      send(16'hA1B1, 2'b11);
      send(16'hA2B2, 2'b11);
      send(16'hA3B3, 2'b11);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("stall_valid", {31'd0, out_valid}, 32'd1);
         chk("stall_field", {24'd0, out_field}, 32'h0A1);
         chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      drain("drain_stall");

      // low-first instance
      expect_b(8'h34, 1'b0, 1'b0);
      expect_b(8'h12, 1'b1, 1'b1);
      @(negedge clk);
      b_in_valid = 1'b1; b_in_word = 16'h1234; b_in_fmask = 2'b11;
      g = 0;
      while (!b_in_ready && g < 200) begin
         @(negedge clk);
         g++;
      end
      chk("b_in_ready_wait", {31'd0, b_in_ready}, 32'd1);
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      drain("drain_low_first");

      // reset in the middle of a stalled word with another word buffered
      out_ready = 1'b0;
      send(16'hEEEE, 2'b11);
      send(16'hDDDD, 2'b11);
      repeat (3) @(negedge clk);
      chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_out_field", {24'd0, out_field}, 32'd0);
      chk("midrst_out_idx", {31'd0, out_idx}, 32'd0);
      chk("midrst_out_last", {31'd0, out_last}, 32'd0);
      chk("midrst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      expect_a(8'h5A, 1'b0, 1'b1);
      send(16'h3C5A, 2'b01);
      drain("drain_after_reset");
      repeat (10) @(negedge clk);
      chk("post_reset_idle", {31'd0, out_valid}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
